// File: rtl/eh2_posit_sched_if.sv
// ----------------------------------------------------------------------------
// eh2_posit_sched_if
// Bundles every non-clock signal of the two-thread posit scheduler.
//   request side : req_valid/req_ready/req_op/req_rs1/req_rs2/req_tag, flush
//   datapath side: dp_valid/dp_op/dp_rs1/dp_rs2 (issue), dp_res_valid/dp_res_data
//   result side  : res_valid/res_ready/res_data/res_tid/res_tag, seq_err
// Modports:
//   master - the environment (threads, datapath, result consumer)
//   slave  - the scheduler itself
// ----------------------------------------------------------------------------
interface eh2_posit_sched_if #(
    parameter int POSIT_LEN = 16,
    parameter int OP_W      = 2,
    parameter int TAG_W     = 5
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [2*OP_W-1:0]      req_op;
    logic [2*POSIT_LEN-1:0] req_rs1;
    logic [2*POSIT_LEN-1:0] req_rs2;
    logic [2*TAG_W-1:0]     req_tag;
    logic [1:0]             flush;
    logic                   dp_valid;
    logic [OP_W-1:0]        dp_op;
    logic [POSIT_LEN-1:0]   dp_rs1;
    logic [POSIT_LEN-1:0]   dp_rs2;
    logic                   dp_res_valid;
    logic [POSIT_LEN-1:0]   dp_res_data;
    logic                   res_valid;
    logic                   res_ready;
    logic [POSIT_LEN-1:0]   res_data;
    logic                   res_tid;
    logic [TAG_W-1:0]       res_tag;
    logic                   seq_err;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, flush,
               dp_res_valid, dp_res_data, res_ready,
        input  req_ready, dp_valid, dp_op, dp_rs1, dp_rs2,
               res_valid, res_data, res_tid, res_tag, seq_err
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, flush,
               dp_res_valid, dp_res_data, res_ready,
        output req_ready, dp_valid, dp_op, dp_rs1, dp_rs2,
               res_valid, res_data, res_tid, res_tag, seq_err
    );
endinterface

// File: rtl/eh2_posit_sched.sv
// ----------------------------------------------------------------------------
// eh2_posit_sched
// Two-thread scheduler in front of the fixed-latency posit datapath.
// Requests from both EH2 threads are arbitrated round-robin, at most one op
// per cycle is issued, in-flight ops are tracked in a LATENCY-deep shift
// register and their results are queued in a FIFO whose space is reserved
// at issue time (credit), so a result can never be dropped except by flush.
// Ports:
//   clk   - clock
//   rst_l - asynchronous active-low reset
//   bus   - eh2_posit_sched_if.slave: request, datapath and result buses
// ----------------------------------------------------------------------------
module eh2_posit_sched #(
    parameter int POSIT_LEN  = 16,
    parameter int OP_W       = 2,
    parameter int TAG_W      = 5,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    eh2_posit_sched_if.slave     bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCN_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + LATENCY + 1);
    localparam int LAST  = LATENCY - 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    // Advance a FIFO pointer with wrap at FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // ---------------- state ----------------
    logic                 rr_q, rr_d;
    logic                 seq_err_q, seq_err_d;
    logic                 trk_v_q    [LATENCY];
    logic                 trk_v_d    [LATENCY];
    logic                 trk_kill_q [LATENCY];
    logic                 trk_kill_d [LATENCY];
    logic                 trk_tid_q  [LATENCY];
    logic                 trk_tid_d  [LATENCY];
    logic [TAG_W-1:0]     trk_tag_q  [LATENCY];
    logic [TAG_W-1:0]     trk_tag_d  [LATENCY];
    logic [POSIT_LEN-1:0] fifo_data_q [FIFO_DEPTH];
    logic [POSIT_LEN-1:0] fifo_data_d [FIFO_DEPTH];
    logic                 fifo_tid_q  [FIFO_DEPTH];
    logic                 fifo_tid_d  [FIFO_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_q  [FIFO_DEPTH];
    logic [TAG_W-1:0]     fifo_tag_d  [FIFO_DEPTH];
    logic                 fifo_kill_q [FIFO_DEPTH];
    logic                 fifo_kill_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [FCN_W-1:0]     fifo_cnt_q, fifo_cnt_d;

    // ---------------- combinational nets ----------------
    logic [1:0]           elig_s;
    logic [1:0]           grant_s;
    logic [1:0]           req_ready_s;
    logic                 credit_ok_s;
    logic                 issue_s;
    logic                 issue_tid_s;
    logic [TAG_W-1:0]     issue_tag_s;
    logic [OP_W-1:0]      dp_op_s;
    logic [POSIT_LEN-1:0] dp_rs1_s;
    logic [POSIT_LEN-1:0] dp_rs2_s;
    logic [CNT_W-1:0]     inflight_s;
    logic [CNT_W-1:0]     occ_s;
    logic                 ret_v_s;
    logic                 ret_kill_s;
    logic                 push_s;
    logic                 nonempty_s;
    logic                 head_tid_s;
    logic                 head_dead_s;
    logic                 res_valid_s;
    logic                 pop_s;

    // Head of the result FIFO: valid, and whether it is killed (stored or by a flush now).
    always_comb begin
        nonempty_s  = (fifo_cnt_q != '0);
        head_tid_s  = fifo_tid_q[rd_ptr_q];
        head_dead_s = fifo_kill_q[rd_ptr_q] | bus.flush[head_tid_s];
        res_valid_s = nonempty_s & ~head_dead_s;
        // A dead head leaves on its own; a live one leaves on handshake.
        pop_s       = nonempty_s & (head_dead_s | bus.res_ready);
    end

    // Occupancy: in-flight ops plus queued results, all holding a FIFO slot.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_s = inflight_s + CNT_W'(trk_v_q[i]);
        end
        occ_s = inflight_s + CNT_W'(fifo_cnt_q);
    end

    // Round-robin arbitration, credit gating and issue muxing.
    always_comb begin
        elig_s = bus.req_valid & ~bus.flush;
        if (elig_s == 2'b11) begin
            // rr_q holds the last granted thread; the other one wins now.
            grant_s = rr_q ? 2'b01 : 2'b10;
        end else begin
            grant_s = elig_s;
        end
        // A slot freed by this cycle's pop may be reused immediately.
        credit_ok_s = rst_l & ((occ_s < DEPTH_C) | ((occ_s == DEPTH_C) & pop_s));
        if (credit_ok_s) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
        issue_s     = |(bus.req_valid & req_ready_s);
        issue_tid_s = req_ready_s[1];
        if (issue_s) begin
            if (issue_tid_s) begin
                dp_op_s     = bus.req_op[2*OP_W-1:OP_W];
                dp_rs1_s    = bus.req_rs1[2*POSIT_LEN-1:POSIT_LEN];
                dp_rs2_s    = bus.req_rs2[2*POSIT_LEN-1:POSIT_LEN];
                issue_tag_s = bus.req_tag[2*TAG_W-1:TAG_W];
            end else begin
                dp_op_s     = bus.req_op[OP_W-1:0];
                dp_rs1_s    = bus.req_rs1[POSIT_LEN-1:0];
                dp_rs2_s    = bus.req_rs2[POSIT_LEN-1:0];
                issue_tag_s = bus.req_tag[TAG_W-1:0];
            end
            rr_d = issue_tid_s;
        end else begin
            dp_op_s     = '0;
            dp_rs1_s    = '0;
            dp_rs2_s    = '0;
            issue_tag_s = '0;
            rr_d        = rr_q;
        end
    end

    // Tracker shift register; flush marks matching stages killed as they move.
    always_comb begin
        trk_v_d[0]    = issue_s;
        trk_kill_d[0] = issue_s & bus.flush[issue_tid_s];
        trk_tid_d[0]  = issue_s & issue_tid_s;
        trk_tag_d[0]  = issue_tag_s;
        for (int i = 1; i < LATENCY; i++) begin
            trk_v_d[i]    = trk_v_q[i-1];
            trk_kill_d[i] = trk_kill_q[i-1] | (trk_v_q[i-1] & bus.flush[trk_tid_q[i-1]]);
            trk_tid_d[i]  = trk_tid_q[i-1];
            trk_tag_d[i]  = trk_tag_q[i-1];
        end
    end

    // Retire of the last tracker stage and datapath agreement check.
    always_comb begin
        ret_v_s    = trk_v_q[LAST];
        ret_kill_s = trk_kill_q[LAST] | bus.flush[trk_tid_q[LAST]];
        push_s     = ret_v_s & ~ret_kill_s;
        seq_err_d  = seq_err_q | (bus.dp_res_valid != ret_v_s);
    end

    // Result FIFO storage, kill marking and pointer/count update.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_d[i] = fifo_data_q[i];
            fifo_tid_d[i]  = fifo_tid_q[i];
            fifo_tag_d[i]  = fifo_tag_q[i];
            fifo_kill_d[i] = fifo_kill_q[i] | bus.flush[fifo_tid_q[i]];
        end
        if (push_s) begin
            fifo_data_d[wr_ptr_q] = bus.dp_res_data;
            fifo_tid_d[wr_ptr_q]  = trk_tid_q[LAST];
            fifo_tag_d[wr_ptr_q]  = trk_tag_q[LAST];
            fifo_kill_d[wr_ptr_q] = 1'b0;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        fifo_cnt_d = fifo_cnt_q + FCN_W'(push_s) - FCN_W'(pop_s);
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rr_q       <= 1'b0;
            seq_err_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                trk_v_q[i]    <= 1'b0;
                trk_kill_q[i] <= 1'b0;
                trk_tid_q[i]  <= 1'b0;
                trk_tag_q[i]  <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_tid_q[i]  <= 1'b0;
                fifo_tag_q[i]  <= '0;
                fifo_kill_q[i] <= 1'b0;
            end
        end else begin
            rr_q       <= rr_d;
            seq_err_q  <= seq_err_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            for (int i = 0; i < LATENCY; i++) begin
                trk_v_q[i]    <= trk_v_d[i];
                trk_kill_q[i] <= trk_kill_d[i];
                trk_tid_q[i]  <= trk_tid_d[i];
                trk_tag_q[i]  <= trk_tag_d[i];
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= fifo_data_d[i];
                fifo_tid_q[i]  <= fifo_tid_d[i];
                fifo_tag_q[i]  <= fifo_tag_d[i];
                fifo_kill_q[i] <= fifo_kill_d[i];
            end
        end
    end

    // Outputs; result fields read as zero whenever no result is offered.
    assign bus.req_ready = req_ready_s;
    assign bus.dp_valid  = issue_s;
    assign bus.dp_op     = dp_op_s;
    assign bus.dp_rs1    = dp_rs1_s;
    assign bus.dp_rs2    = dp_rs2_s;
    assign bus.res_valid = res_valid_s;
    assign bus.res_data  = res_valid_s ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.res_tid   = res_valid_s & head_tid_s;
    assign bus.res_tag   = res_valid_s ? fifo_tag_q[rd_ptr_q] : '0;
    assign bus.seq_err   = seq_err_q;
endmodule
